// File: rtl/rvfi_tl_pkg.sv
// Shared TileLink-UL constants, queue-entry header type and A-to-D opcode mapping
// for the RVFI TileLink slave stub.
package rvfi_tl_pkg;

    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] ARITH           = 3'd2;
    localparam logic [2:0] LOGIC           = 3'd3;
    localparam logic [2:0] GET             = 3'd4;
    localparam logic [2:0] HINT            = 3'd5;

    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    // Width-independent part of a queued response; size, source and data are appended by the stub.
    typedef struct packed {
        logic [2:0] opcode;
        logic       denied;
    } entry_hdr_t;

    function automatic entry_hdr_t map_opcode(input logic [2:0] a_op);
        entry_hdr_t hdr;
        case (a_op)
            GET: begin
                hdr.opcode = ACCESS_ACK_DATA;
                hdr.denied = 1'b0;
            end
            PUT_FULL, PUT_PARTIAL: begin
                hdr.opcode = ACCESS_ACK;
                hdr.denied = 1'b0;
            end
            ARITH, LOGIC, HINT: begin
                hdr.opcode = ACCESS_ACK;
                hdr.denied = 1'b1;
            end
            default: begin
                hdr.opcode = ACCESS_ACK;
                hdr.denied = 1'b1;
            end
        endcase
        return hdr;
    endfunction

endpackage

// File: rtl/rvfi_tl_fifo.sv
// Generic DEPTH-entry synchronous FIFO (DEPTH a power of two) with full/empty flags.
// Push is ignored when full and pop is ignored when empty.
module rvfi_tl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL  = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW:0]      count_r;
    logic             push_s;
    logic             pop_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == {(PW+1){1'b0}});
    assign push_s    = push && !full;
    assign pop_s     = pop && !empty;
    assign head_data = mem_r[rd_ptr_r];

    // Storage array; contents are only meaningful while the matching slot is occupied.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/rvfi_tl_stub.sv
// RVFI harness glue: held-off core reset sequencer plus an in-order TileLink-UL slave
// that answers after a programmable latency. Optional stall inputs: RVFI_TL_STUB_STALL_EN.
module rvfi_tl_stub
    import rvfi_tl_pkg::*;
#(
    parameter int RESET_CYCLES = 2,
    parameter int DEPTH        = 4,
    parameter int LATENCY      = 1,
    parameter int AW           = 32,
    parameter int DW           = 64,
    parameter int SZW          = 3,
    parameter int SRCW         = 3
) (
    input  logic              clock,
    input  logic              reset,
    output logic              core_reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [2:0]        a_opcode,
    input  logic [2:0]        a_param,
    input  logic [SZW-1:0]    a_size,
    input  logic [SRCW-1:0]   a_source,
    input  logic [AW-1:0]     a_address,
    input  logic [DW/8-1:0]   a_mask,
    input  logic [DW-1:0]     a_data,
`ifdef RVFI_TL_STUB_STALL_EN
    input  logic              stall_a,
    input  logic              stall_d,
`endif
    output logic              d_valid,
    input  logic              d_ready,
    output logic [2:0]        d_opcode,
    output logic [1:0]        d_param,
    output logic [SZW-1:0]    d_size,
    output logic [SRCW-1:0]   d_source,
    output logic [1:0]        d_sink,
    output logic              d_denied,
    output logic              d_corrupt,
    output logic [DW-1:0]     d_data,
    input  logic [DW-1:0]     rand_data
);

    localparam int         HW        = $bits(entry_hdr_t);
    localparam int         EW        = HW + SZW + SRCW + DW;
    localparam logic [7:0] HOLD_LAST = 8'(RESET_CYCLES - 1);
    localparam logic [3:0] WAIT_MAX  = 4'(LATENCY);

    logic          core_reset_r;
    logic [7:0]    hold_r;
    logic [3:0]    wait_r;
    logic          full_s;
    logic          empty_s;
    logic          a_ready_s;
    logic          d_valid_s;
    logic          push_s;
    logic          pop_s;
    entry_hdr_t    push_hdr_s;
    entry_hdr_t    head_hdr_s;
    logic [DW-1:0] push_payload_s;
    logic [EW-1:0] push_entry_s;
    logic [EW-1:0] head_entry_s;
    logic          unused_s;

    assign unused_s = ^{a_param, a_address, a_mask, a_data};

    // Hold the core in reset for RESET_CYCLES cycles after the harness reset falls.
    always_ff @(posedge clock) begin
        if (reset) begin
            core_reset_r <= 1'b1;
            hold_r       <= 8'd0;
        end else if (core_reset_r) begin
            if (hold_r == HOLD_LAST) begin
                core_reset_r <= 1'b0;
            end else begin
                hold_r <= hold_r + 8'd1;
            end
        end else begin
            core_reset_r <= 1'b0;
        end
    end

`ifdef RVFI_TL_STUB_STALL_EN
    logic presenting_r;
    assign a_ready_s = !core_reset_r && !full_s && !stall_a;
    // A response already on the bus ignores stall_d so d_valid never retracts.
    assign d_valid_s = !empty_s && (wait_r == WAIT_MAX) && (presenting_r || !stall_d);

    // Remember that a response is being presented but not yet taken.
    always_ff @(posedge clock) begin
        if (reset) begin
            presenting_r <= 1'b0;
        end else begin
            presenting_r <= d_valid_s && !d_ready;
        end
    end
`else
    assign a_ready_s = !core_reset_r && !full_s;
    assign d_valid_s = !empty_s && (wait_r == WAIT_MAX);
`endif

    assign push_s         = a_valid && a_ready_s;
    assign pop_s          = d_valid_s && d_ready;
    assign push_hdr_s     = map_opcode(a_opcode);
    assign push_payload_s = (a_opcode == GET) ? rand_data : {DW{1'b0}};
    assign push_entry_s   = {push_hdr_s, a_size, a_source, push_payload_s};
    assign head_hdr_s     = head_entry_s[EW-1 -: HW];

    rvfi_tl_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head_data (head_entry_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Head wait counter: restarts whenever a different entry becomes head.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_r <= 4'd0;
        end else if (pop_s || (push_s && empty_s)) begin
            wait_r <= 4'd0;
        end else if (!empty_s && (wait_r != WAIT_MAX)) begin
            wait_r <= wait_r + 4'd1;
        end else begin
            wait_r <= wait_r;
        end
    end

    assign core_reset = core_reset_r;
    assign a_ready    = a_ready_s;
    assign d_valid    = d_valid_s;
    assign d_param    = 2'd0;
    assign d_sink     = 2'd0;
    assign d_corrupt  = 1'b0;

    // D fields come from the head entry and read as zero when nothing is presented.
    always_comb begin
        d_opcode = 3'd0;
        d_denied = 1'b0;
        d_size   = {SZW{1'b0}};
        d_source = {SRCW{1'b0}};
        d_data   = {DW{1'b0}};
        if (d_valid_s) begin
            d_opcode = head_hdr_s.opcode;
            d_denied = head_hdr_s.denied;
            d_size   = head_entry_s[SRCW+DW +: SZW];
            d_source = head_entry_s[DW +: SRCW];
            d_data   = head_entry_s[DW-1:0];
        end else begin
            d_opcode = 3'd0;
            d_denied = 1'b0;
            d_size   = {SZW{1'b0}};
            d_source = {SRCW{1'b0}};
            d_data   = {DW{1'b0}};
        end
    end

endmodule

// File: tb/tb_rvfi_tl_stub.sv
// Self-checking bench for rvfi_tl_stub: directed scenario tasks plus a randomized run
// checked against a queue-based response model.
module tb_rvfi_tl_stub;

    localparam int RESET_CYCLES = 2;
    localparam int DEPTH        = 4;
    localparam int LATENCY      = 1;

    logic        clock;
    logic        reset;
    logic        core_reset;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [2:0]  a_source;
    logic [31:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic [2:0]  d_source;
    logic [1:0]  d_sink;
    logic        d_denied;
    logic        d_corrupt;
    logic [63:0] d_data;
    logic [63:0] rand_data;
`ifdef RVFI_TL_STUB_STALL_EN
    logic        stall_a;
    logic        stall_d;
`endif

    int n_total;
    int n_pass;

    typedef struct {
        logic [2:0]  op;
        logic        den;
        logic [2:0]  size;
        logic [2:0]  src;
        logic [63:0] data;
    } rsp_t;

    rvfi_tl_stub #(
        .RESET_CYCLES (RESET_CYCLES),
        .DEPTH        (DEPTH),
        .LATENCY      (LATENCY)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .core_reset (core_reset),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_opcode   (a_opcode),
        .a_param    (a_param),
        .a_size     (a_size),
        .a_source   (a_source),
        .a_address  (a_address),
        .a_mask     (a_mask),
        .a_data     (a_data),
`ifdef RVFI_TL_STUB_STALL_EN
        .stall_a    (stall_a),
        .stall_d    (stall_d),
`endif
        .d_valid    (d_valid),
        .d_ready    (d_ready),
        .d_opcode   (d_opcode),
        .d_param    (d_param),
        .d_size     (d_size),
        .d_source   (d_source),
        .d_sink     (d_sink),
        .d_denied   (d_denied),
        .d_corrupt  (d_corrupt),
        .d_data     (d_data),
        .rand_data  (rand_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle_inputs();
        a_valid   = 1'b0;
        a_opcode  = 3'd0;
        a_param   = 3'd0;
        a_size    = 3'd0;
        a_source  = 3'd0;
        a_address = 32'd0;
        a_mask    = 8'd0;
        a_data    = 64'd0;
        d_ready   = 1'b0;
        rand_data = 64'd0;
`ifdef RVFI_TL_STUB_STALL_EN
        stall_a   = 1'b0;
        stall_d   = 1'b0;
`endif
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clock);
        n_total++; if (core_reset !== 1'b1) $display("FAIL rst_core_reset: got %0b want 1", core_reset); else n_pass++;
        n_total++; if (a_ready !== 1'b0) $display("FAIL rst_a_ready: got %0b want 0", a_ready); else n_pass++;
        n_total++; if (d_valid !== 1'b0) $display("FAIL rst_d_valid: got %0b want 0", d_valid); else n_pass++;
        n_total++; if ({d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data} !== 80'd0)
            $display("FAIL rst_d_fields: got nonzero d_* fields data=%0h", d_data); else n_pass++;
        reset = 1'b0;
        for (int i = 0; i < RESET_CYCLES; i++) begin
            n_total++; if (core_reset !== 1'b1) $display("FAIL hold_core_reset[%0d]: got %0b want 1", i, core_reset); else n_pass++;
            n_total++; if (a_ready !== 1'b0) $display("FAIL hold_a_ready[%0d]: got %0b want 0", i, a_ready); else n_pass++;
            @(negedge clock);
        end
        n_total++; if (core_reset !== 1'b0) $display("FAIL release_core_reset: got %0b want 0", core_reset); else n_pass++;
        n_total++; if (a_ready !== 1'b1) $display("FAIL release_a_ready: got %0b want 1", a_ready); else n_pass++;
        repeat (4) @(negedge clock);
        n_total++; if (core_reset !== 1'b0) $display("FAIL core_reset_sticky: got %0b want 0", core_reset); else n_pass++;
    endtask

    task automatic test_get();
        d_ready   = 1'b1;
        a_valid   = 1'b1;
        a_opcode  = 3'd4;
        a_size    = 3'd3;
        a_source  = 3'd5;
        a_address = 32'h8000_0040;
        rand_data = 64'hDEADBEEF_CAFEF00D;
        n_total++; if (a_ready !== 1'b1) $display("FAIL get_a_ready: got %0b want 1", a_ready); else n_pass++;
        @(negedge clock);
        a_valid   = 1'b0;
        rand_data = 64'h0123_4567_89AB_CDEF;
        n_total++; if (d_valid !== 1'b0) $display("FAIL get_early_d_valid: got %0b want 0", d_valid); else n_pass++;
        @(negedge clock);
        rand_data = 64'hFFFF_0000_FFFF_0000;
        n_total++; if (d_valid !== 1'b1) $display("FAIL get_d_valid: got %0b want 1", d_valid); else n_pass++;
        n_total++; if (d_opcode !== 3'd1) $display("FAIL get_d_opcode: got %0d want 1", d_opcode); else n_pass++;
        n_total++; if (d_source !== 3'd5) $display("FAIL get_d_source: got %0d want 5", d_source); else n_pass++;
        n_total++; if (d_size !== 3'd3) $display("FAIL get_d_size: got %0d want 3", d_size); else n_pass++;
        n_total++; if (d_data !== 64'hDEADBEEF_CAFEF00D) $display("FAIL get_d_data: got %0h want deadbeefcafef00d", d_data); else n_pass++;
        n_total++; if (d_denied !== 1'b0) $display("FAIL get_d_denied: got %0b want 0", d_denied); else n_pass++;
        @(negedge clock);
        n_total++; if (d_valid !== 1'b0) $display("FAIL get_popped: got %0b want 0", d_valid); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_opcode_map();
        logic [63:0] rd;
        logic [2:0]  exp_op;
        logic        exp_den;
        logic [63:0] exp_data;
        logic        found;
        for (int op = 0; op < 8; op++) begin
            rd        = {$urandom, $urandom} | 64'h1;
            exp_op    = (op == 4) ? 3'd1 : 3'd0;
            exp_den   = !(op == 0 || op == 1 || op == 4);
            exp_data  = (op == 4) ? rd : 64'd0;
            a_valid   = 1'b1;
            a_opcode  = 3'(op);
            a_size    = 3'($urandom_range(0, 3));
            a_source  = 3'(op);
            a_data    = {$urandom, $urandom};
            rand_data = rd;
            d_ready   = 1'b1;
            @(negedge clock);
            a_valid   = 1'b0;
            rand_data = ~rd;
            found     = 1'b0;
            for (int k = 0; k < 6 && !found; k++) begin
                if (d_valid) found = 1'b1;
                else @(negedge clock);
            end
            n_total++; if (found !== 1'b1) $display("FAIL map_timeout[%0d]: got no d_valid want d_valid", op); else n_pass++;
            n_total++; if (d_opcode !== exp_op) $display("FAIL map_opcode[%0d]: got %0d want %0d", op, d_opcode, exp_op); else n_pass++;
            n_total++; if (d_denied !== exp_den) $display("FAIL map_denied[%0d]: got %0b want %0b", op, d_denied, exp_den); else n_pass++;
            n_total++; if (d_data !== exp_data) $display("FAIL map_data[%0d]: got %0h want %0h", op, d_data, exp_data); else n_pass++;
            n_total++; if (d_source !== 3'(op)) $display("FAIL map_source[%0d]: got %0d want %0d", op, d_source, op); else n_pass++;
            @(negedge clock);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        int got[$];
        d_ready  = 1'b0;
        a_opcode = 3'd0;
        for (int i = 0; i < DEPTH; i++) begin
            a_valid  = 1'b1;
            a_source = 3'(i);
            n_total++; if (a_ready !== 1'b1) $display("FAIL b2b_accept[%0d]: got %0b want 1", i, a_ready); else n_pass++;
            @(negedge clock);
        end
        a_source = 3'd4;
        n_total++; if (a_ready !== 1'b0) $display("FAIL b2b_full: got %0b want 0", a_ready); else n_pass++;
        @(negedge clock);
        n_total++; if (a_ready !== 1'b0) $display("FAIL b2b_held: got %0b want 0", a_ready); else n_pass++;
        n_total++; if (d_valid !== 1'b1) $display("FAIL b2b_head_valid: got %0b want 1", d_valid); else n_pass++;
        d_ready = 1'b1;
        if (d_valid) got.push_back(int'(d_source));
        @(negedge clock);
        n_total++; if (a_ready !== 1'b1) $display("FAIL b2b_ready_after_pop: got %0b want 1", a_ready); else n_pass++;
        if (d_valid) got.push_back(int'(d_source));
        @(negedge clock);
        a_valid = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (d_valid) begin
                got.push_back(int'(d_source));
                n_total++; if (d_opcode !== 3'd0) $display("FAIL b2b_opcode: got %0d want 0", d_opcode); else n_pass++;
            end
            @(negedge clock);
        end
        n_total++; if (got.size() != 5) $display("FAIL b2b_count: got %0d want 5", got.size()); else n_pass++;
        for (int i = 0; i < got.size() && i < 5; i++) begin
            n_total++; if (got[i] != i) $display("FAIL b2b_order[%0d]: got %0d want %0d", i, got[i], i); else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_reset_flush();
        int seen;
        d_ready  = 1'b0;
        a_opcode = 3'd4;
        for (int i = 1; i <= 3; i++) begin
            a_valid   = 1'b1;
            a_source  = 3'(i);
            rand_data = {$urandom, $urandom};
            @(negedge clock);
        end
        a_valid = 1'b0;
        repeat (2) @(negedge clock);
        n_total++; if (d_valid !== 1'b1) $display("FAIL flush_pre_valid: got %0b want 1", d_valid); else n_pass++;
        reset = 1'b1;
        @(negedge clock);
        n_total++; if (d_valid !== 1'b0) $display("FAIL flush_d_valid: got %0b want 0", d_valid); else n_pass++;
        n_total++; if (core_reset !== 1'b1) $display("FAIL flush_core_reset: got %0b want 1", core_reset); else n_pass++;
        n_total++; if (a_ready !== 1'b0) $display("FAIL flush_a_ready: got %0b want 0", a_ready); else n_pass++;
        reset = 1'b0;
        repeat (RESET_CYCLES) @(negedge clock);
        n_total++; if (core_reset !== 1'b0) $display("FAIL flush_release: got %0b want 0", core_reset); else n_pass++;
        d_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            if (d_valid) seen++;
            @(negedge clock);
        end
        n_total++; if (seen != 0) $display("FAIL flush_stale: got %0d responses want 0", seen); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_random();
        rsp_t q[$];
        rsp_t e;
        int   cyc;
        int   head_since;
        logic exp_ar;
        logic exp_dv;
        logic acc;
        logic pop;
        logic was_empty;
        cyc = 0;
        head_since = 0;
        for (int c = 0; c < 400; c++) begin
            exp_ar = (q.size() < DEPTH);
            exp_dv = (q.size() > 0) && ((cyc - head_since) >= LATENCY);
            n_total++; if (a_ready !== exp_ar) $display("FAIL rnd_a_ready@%0d: got %0b want %0b", c, a_ready, exp_ar); else n_pass++;
            n_total++; if (d_valid !== exp_dv) $display("FAIL rnd_d_valid@%0d: got %0b want %0b", c, d_valid, exp_dv); else n_pass++;
            if (exp_dv) begin
                n_total++;
                if (d_opcode !== q[0].op || d_denied !== q[0].den || d_size !== q[0].size ||
                    d_source !== q[0].src || d_data !== q[0].data)
                    $display("FAIL rnd_d_fields@%0d: got op=%0d den=%0b sz=%0d src=%0d data=%0h want op=%0d den=%0b sz=%0d src=%0d data=%0h",
                             c, d_opcode, d_denied, d_size, d_source, d_data,
                             q[0].op, q[0].den, q[0].size, q[0].src, q[0].data);
                else n_pass++;
            end
            a_valid   = ($urandom_range(0, 3) != 0);
            a_opcode  = 3'($urandom_range(0, 7));
            a_size    = 3'($urandom_range(0, 3));
            a_source  = 3'($urandom_range(0, 7));
            a_address = $urandom;
            rand_data = {$urandom, $urandom};
            d_ready   = ($urandom_range(0, 1) != 0);
            e.op      = (a_opcode == 3'd4) ? 3'd1 : 3'd0;
            e.den     = !(a_opcode == 3'd0 || a_opcode == 3'd1 || a_opcode == 3'd4);
            e.size    = a_size;
            e.src     = a_source;
            e.data    = (a_opcode == 3'd4) ? rand_data : 64'd0;
            acc       = a_valid && exp_ar;
            pop       = exp_dv && d_ready;
            was_empty = (q.size() == 0);
            @(negedge clock);
            cyc++;
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
            if ((pop || was_empty) && q.size() > 0) head_since = cyc;
        end
        idle_inputs();
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        reset   = 1'b1;
        idle_inputs();
        test_reset();
        test_get();
        test_opcode_map();
        test_back_to_back();
        test_reset_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion want completion");
        $fatal(1, "timeout");
    end

endmodule
